// File: rtl/load_store_unit.sv
// load_store_unit: MEMPREP/MEMEX data-memory path.
// P (comb decode) -> X (TCM / MMIO access) -> W (lane select + extend).
// One operation per cycle, no back-pressure; results are valid two cycles
// after an op is presented.
module load_store_unit #(
  parameter int          DTCM_ADDR_W = 12,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data_wb,
  output logic        load_valid_wb,
  output logic [1:0]  fault_wb,
  output logic [31:0] mmio_out
);

  localparam int IDX_W = DTCM_ADDR_W - 2;
  localparam int WORDS = 2 ** IDX_W;

  typedef enum logic [1:0] {
    REG_NONE = 2'b00,
    REG_DTCM = 2'b01,
    REG_MMIO = 2'b10
  } region_e;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_MISALGN = 2'b01;
  localparam logic [1:0] FLT_ACCESS  = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL = 2'b11;

  // ---------------- Stage P decode outputs (next state of P->X) ----------
  logic             x_valid_d;
  region_e          x_region_d;
  logic [3:0]       x_be_d;
  logic [31:0]      x_wdata_d;
  logic [1:0]       x_fault_d;
  logic             p_illegal;
  logic             p_misaligned;

  // ---------------- P->X register ----------------------------------------
  logic             x_valid_q;
  logic             x_load_q;
  logic             x_store_q;
  region_e          x_region_q;
  logic [IDX_W-1:0] x_idx_q;
  logic [3:0]       x_be_q;
  logic [31:0]      x_wdata_q;
  logic [1:0]       x_off_q;
  logic [2:0]       x_funct3_q;
  logic [1:0]       x_fault_q;

  // ---------------- X->W register ----------------------------------------
  logic             w_valid_q;
  logic             w_load_q;
  logic [1:0]       w_off_q;
  logic [2:0]       w_funct3_q;
  logic [1:0]       w_fault_q;
  region_e          w_region_q;
  logic [31:0]      mmio_rd_q;
  logic [31:0]      dtcm_rd;

  logic [31:0]      mmio_q;
  logic             x_wr_ok;
  logic             dtcm_we;
  logic             mmio_we;

  // Decode region, byte enables, lane-aligned store data and fault cause.
  always_comb begin
    x_valid_d  = in_valid & (mem_load | mem_store);
    x_region_d = REG_NONE;
    if (addr[31:DTCM_ADDR_W] == '0) begin
      x_region_d = REG_DTCM;
    end else if (addr[31:2] == MMIO_BASE[31:2]) begin
      x_region_d = REG_MMIO;
    end

    case (mem_funct3[1:0])
      2'b00:   x_be_d = 4'b0001 << addr[1:0];
      2'b01:   x_be_d = 4'b0011 << addr[1:0];
      default: x_be_d = 4'b1111;
    endcase

    x_wdata_d = store_data << {addr[1:0], 3'b000};

    p_illegal = (mem_load & mem_store) || (mem_funct3 == 3'b011) ||
                (mem_funct3 == 3'b110) || (mem_funct3 == 3'b111);
    p_misaligned = ((mem_funct3[1:0] == 2'b01) && addr[0]) ||
                   ((mem_funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

    x_fault_d = FLT_NONE;
    if (x_valid_d) begin
      if (p_illegal) begin
        x_fault_d = FLT_ILLEGAL;
      end else if (p_misaligned) begin
        x_fault_d = FLT_MISALGN;
      end else if (x_region_d == REG_NONE) begin
        x_fault_d = FLT_ACCESS;
      end
    end
  end

  // P->X pipeline register; only the valid bit needs reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_valid_q <= 1'b0;
    end else begin
      x_valid_q <= x_valid_d;
    end
    x_load_q   <= mem_load;
    x_store_q  <= mem_store;
    x_region_q <= x_region_d;
    x_idx_q    <= addr[DTCM_ADDR_W-1:2];
    x_be_q     <= x_be_d;
    x_wdata_q  <= x_wdata_d;
    x_off_q    <= addr[1:0];
    x_funct3_q <= mem_funct3;
    x_fault_q  <= x_fault_d;
  end

  // A store reaching X while reset is high is dropped.
  assign x_wr_ok = x_valid_q & x_store_q & (x_fault_q == FLT_NONE) & ~rst;
  assign dtcm_we = x_wr_ok & (x_region_q == REG_DTCM);
  assign mmio_we = x_wr_ok & (x_region_q == REG_MMIO);

  // DTCM as four byte-wide lanes so each lane maps onto a plain RAM with
  // its own write enable; reads are registered and read-first.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [WORDS];
      logic [7:0] rd_q;

      // Byte-lane write and registered read of the addressed word.
      always_ff @(posedge clk) begin
        if (dtcm_we && x_be_q[gi]) begin
          mem[x_idx_q] <= x_wdata_q[8*gi +: 8];
        end
        rd_q <= mem[x_idx_q];
      end

      assign dtcm_rd[8*gi +: 8] = rd_q;
    end
  endgenerate

  // MMIO output register with per-byte writes; the old value is captured
  // alongside so an MMIO load sees the pre-store contents of its own cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_q <= '0;
    end else if (mmio_we) begin
      for (int b = 0; b < 4; b++) begin
        if (x_be_q[b]) begin
          mmio_q[8*b +: 8] <= x_wdata_q[8*b +: 8];
        end
      end
    end
    mmio_rd_q <= mmio_q;
  end

  // X->W pipeline register; in-flight ops are discarded on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid_q <= 1'b0;
    end else begin
      w_valid_q <= x_valid_q;
    end
    w_load_q   <= x_load_q;
    w_off_q    <= x_off_q;
    w_funct3_q <= x_funct3_q;
    w_fault_q  <= x_fault_q;
    w_region_q <= x_region_q;
  end

  logic [31:0] w_raw;
  logic [31:0] w_lane;
  logic [31:0] w_ext;

  // Select the addressed lane, extend per funct3, and gate faulting loads.
  always_comb begin
    w_raw  = (w_region_q == REG_MMIO) ? mmio_rd_q : dtcm_rd;
    w_lane = w_raw >> {w_off_q, 3'b000};
    case (w_funct3_q)
      3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_ext = w_raw;
      3'b100:  w_ext = {24'd0, w_lane[7:0]};
      3'b101:  w_ext = {16'd0, w_lane[15:0]};
      default: w_ext = '0;
    endcase

    load_valid_wb = w_valid_q & w_load_q;
    fault_wb      = w_valid_q ? w_fault_q : FLT_NONE;
    load_data_wb  = (load_valid_wb && (w_fault_q == FLT_NONE)) ? w_ext : '0;
  end

  assign mmio_out = mmio_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed test-plan sequence, randomized
// traffic against a byte-level memory model, and reset behaviour.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        mem_load;
  logic        mem_store;
  logic [2:0]  mem_funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] load_data_wb;
  logic        load_valid_wb;
  logic [1:0]  fault_wb;
  logic [31:0] mmio_out;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] MMIO_ADDR = 32'h8000_0000;

  typedef struct {
    bit          v;
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
  } op_t;

  // Reference state: byte-addressed data memory and the MMIO word.
  logic [7:0]  mref [4096];
  logic [31:0] mmio_ref;

  load_store_unit #(.DTCM_ADDR_W(12), .MMIO_BASE(32'h8000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .mem_load      (mem_load),
    .mem_store     (mem_store),
    .mem_funct3    (mem_funct3),
    .addr          (addr),
    .store_data    (store_data),
    .load_data_wb  (load_data_wb),
    .load_valid_wb (load_valid_wb),
    .fault_wb      (fault_wb),
    .mmio_out      (mmio_out)
  );

  always #5 clk = ~clk;

  // Architectural effect of one op, applied in program order.
  function automatic void model(input op_t o, output bit ev,
                                output logic [1:0] ef, output logic [31:0] ed);
    int          size;
    bit          is_dtcm;
    bit          is_mmio;
    logic [31:0] val;
    logic [31:0] ba;
    ev = 1'b0; ef = 2'b00; ed = 32'd0; val = 32'd0;
    if (!o.v || !(o.ld || o.st)) return;
    ev = o.ld;
    if ((o.ld && o.st) || o.f3 == 3'd3 || o.f3 == 3'd6 || o.f3 == 3'd7) begin
      ef = 2'b11;
      return;
    end
    size = (o.f3[1:0] == 2'd0) ? 1 : (o.f3[1:0] == 2'd1) ? 2 : 4;
    if ((int'(o.a[1:0]) % size) != 0) begin
      ef = 2'b01;
      return;
    end
    is_dtcm = (o.a < 32'd4096);
    is_mmio = ((o.a >> 2) == (MMIO_ADDR >> 2));
    if (!is_dtcm && !is_mmio) begin
      ef = 2'b10;
      return;
    end
    for (int b = 0; b < size; b++) begin
      ba = o.a + 32'(b);
      if (o.ld) begin
        if (is_dtcm) val[8*b +: 8] = mref[ba[11:0]];
        else         val[8*b +: 8] = mmio_ref[8*ba[1:0] +: 8];
      end
      if (o.st) begin
        if (is_dtcm) mref[ba[11:0]] = o.d[8*b +: 8];
        else         mmio_ref[8*ba[1:0] +: 8] = o.d[8*b +: 8];
      end
    end
    if (o.ld) begin
      if (!o.f3[2] && size == 1)      ed = {{24{val[7]}}, val[7:0]};
      else if (!o.f3[2] && size == 2) ed = {{16{val[15]}}, val[15:0]};
      else                            ed = val;
    end
  endfunction

  task automatic drive(input op_t o);
    in_valid   = o.v;
    mem_load   = o.ld;
    mem_store  = o.st;
    mem_funct3 = o.f3;
    addr       = o.a;
    store_data = o.d;
  endtask

  function automatic op_t mk(input bit v, input bit ld, input bit st,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] d);
    op_t o;
    o.v = v; o.ld = ld; o.st = st; o.f3 = f3; o.a = a; o.d = d;
    return o;
  endfunction

  task automatic test_reset();
    drive(mk(0, 0, 0, 3'd0, 32'd0, 32'd0));
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (load_data_wb !== 32'd0) begin
      bad++; $display("FAIL reset load_data_wb got %h want 00000000", load_data_wb);
    end
    total++;
    if (load_valid_wb !== 1'b0) begin
      bad++; $display("FAIL reset load_valid_wb got %b want 0", load_valid_wb);
    end
    total++;
    if (fault_wb !== 2'b00) begin
      bad++; $display("FAIL reset fault_wb got %b want 00", fault_wb);
    end
    total++;
    if (mmio_out !== 32'd0) begin
      bad++; $display("FAIL reset mmio_out got %h want 00000000", mmio_out);
    end
    mmio_ref = 32'd0;
    rst = 1'b0;
    $display("reset: outputs cleared check done");
  endtask

  // Test-plan sequence with hand-derived expected results.
  task automatic test_directed();
    op_t         ops[$];
    bit          xv[$];
    logic [1:0]  xf[$];
    logic [31:0] xd[$];
    logic [31:0] xm[$];
    bit          mv;
    logic [1:0]  mf;
    logic [31:0] md;
    ops.push_back(mk(1,0,1,3'd2,32'h10,32'hDEADBEEF)); xv.push_back(0); xf.push_back(0); xd.push_back(32'h0);
    ops.push_back(mk(1,1,0,3'd2,32'h10,32'h0));        xv.push_back(1); xf.push_back(0); xd.push_back(32'hDEADBEEF);
    ops.push_back(mk(1,1,0,3'd0,32'h13,32'h0));        xv.push_back(1); xf.push_back(0); xd.push_back(32'hFFFFFFDE);
    ops.push_back(mk(1,1,0,3'd4,32'h13,32'h0));        xv.push_back(1); xf.push_back(0); xd.push_back(32'h000000DE);
    ops.push_back(mk(1,1,0,3'd1,32'h12,32'h0));        xv.push_back(1); xf.push_back(0); xd.push_back(32'hFFFFDEAD);
    ops.push_back(mk(1,1,0,3'd5,32'h10,32'h0));        xv.push_back(1); xf.push_back(0); xd.push_back(32'h0000BEEF);
    ops.push_back(mk(1,0,1,3'd0,32'h11,32'h55));       xv.push_back(0); xf.push_back(0); xd.push_back(32'h0);
    ops.push_back(mk(1,1,0,3'd2,32'h10,32'h0));        xv.push_back(1); xf.push_back(0); xd.push_back(32'hDEAD55EF);
    ops.push_back(mk(1,0,1,3'd1,32'h11,32'h1234));     xv.push_back(0); xf.push_back(1); xd.push_back(32'h0);
    ops.push_back(mk(1,1,0,3'd2,32'h12,32'h0));        xv.push_back(1); xf.push_back(1); xd.push_back(32'h0);
    ops.push_back(mk(1,1,0,3'd2,32'h10,32'h0));        xv.push_back(1); xf.push_back(0); xd.push_back(32'hDEAD55EF);
    ops.push_back(mk(1,1,0,3'd2,32'h2000,32'h0));      xv.push_back(1); xf.push_back(2); xd.push_back(32'h0);
    ops.push_back(mk(1,1,0,3'd3,32'h10,32'h0));        xv.push_back(1); xf.push_back(3); xd.push_back(32'h0);
    ops.push_back(mk(1,0,1,3'd2,32'h80000000,32'hA));  xv.push_back(0); xf.push_back(0); xd.push_back(32'h0);
    ops.push_back(mk(1,1,0,3'd2,32'h80000000,32'h0));  xv.push_back(1); xf.push_back(0); xd.push_back(32'h0000000A);
    ops.push_back(mk(1,0,1,3'd0,32'h80000001,32'hFF)); xv.push_back(0); xf.push_back(0); xd.push_back(32'h0);
    ops.push_back(mk(1,1,0,3'd2,32'h80000000,32'h0));  xv.push_back(1); xf.push_back(0); xd.push_back(32'h0000FF0A);
    ops.push_back(mk(1,1,0,3'd0,32'h80000001,32'h0));  xv.push_back(1); xf.push_back(0); xd.push_back(32'hFFFFFFFF);
    ops.push_back(mk(1,1,1,3'd2,32'h10,32'h0));        xv.push_back(1); xf.push_back(3); xd.push_back(32'h0);
    ops.push_back(mk(1,1,0,3'd2,32'h10,32'h0));        xv.push_back(1); xf.push_back(0); xd.push_back(32'hDEAD55EF);
    ops.push_back(mk(0,1,0,3'd2,32'h10,32'h0));        xv.push_back(0); xf.push_back(0); xd.push_back(32'h0);
    ops.push_back(mk(1,0,1,3'd2,32'h40000000,32'h1));  xv.push_back(0); xf.push_back(2); xd.push_back(32'h0);
    for (int k = 0; k <= ops.size(); k++) begin
      if (k < ops.size()) begin
        drive(ops[k]);
        model(ops[k], mv, mf, md);
        xm.push_back(mmio_ref);
      end else begin
        drive(mk(0, 0, 0, 3'd0, 32'd0, 32'd0));
      end
      @(posedge clk);
      #1;
      if (k >= 1) begin
        total++;
        if (load_valid_wb !== xv[k-1]) begin
          bad++; $display("FAIL directed op%0d load_valid got %b want %b", k-1, load_valid_wb, xv[k-1]);
        end
        total++;
        if (fault_wb !== xf[k-1]) begin
          bad++; $display("FAIL directed op%0d fault got %b want %b", k-1, fault_wb, xf[k-1]);
        end
        total++;
        if (load_data_wb !== xd[k-1]) begin
          bad++; $display("FAIL directed op%0d load_data got %h want %h", k-1, load_data_wb, xd[k-1]);
        end
        total++;
        if (mmio_out !== xm[k-1]) begin
          bad++; $display("FAIL directed op%0d mmio_out got %h want %h", k-1, mmio_out, xm[k-1]);
        end
        $display("directed op%0d a=%h f3=%0d data=%h fault=%b valid=%b mmio=%h",
                 k-1, ops[k-1].a, ops[k-1].f3, load_data_wb, fault_wb, load_valid_wb, mmio_out);
      end
    end
  endtask

  // Random traffic, back-to-back every cycle, against the byte-level model.
  task automatic test_random();
    op_t         ops[$];
    bit          xv[$];
    logic [1:0]  xf[$];
    logic [31:0] xd[$];
    logic [31:0] xm[$];
    op_t         o;
    int          r;
    bit          mv;
    logic [1:0]  mf;
    logic [31:0] md;
    for (int w = 0; w < 16; w++) ops.push_back(mk(1, 0, 1, 3'd2, 32'(4*w), $urandom));
    for (int i = 0; i < 300; i++) begin
      o.v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 19);
      o.ld = (r < 9) || (r == 19);
      o.st = ((r >= 9) && (r < 17)) || (r == 19);
      r = $urandom_range(0, 9);
      if (r < 8) begin
        case ($urandom_range(0, 4))
          0: o.f3 = 3'd0;
          1: o.f3 = 3'd1;
          2: o.f3 = 3'd2;
          3: o.f3 = 3'd4;
          default: o.f3 = 3'd5;
        endcase
      end else begin
        o.f3 = 3'($urandom_range(0, 7));
      end
      r = $urandom_range(0, 19);
      if (r < 16)      o.a = 32'($urandom_range(0, 63));
      else if (r < 18) o.a = MMIO_ADDR + 32'($urandom_range(0, 3));
      else if (r < 19) o.a = 32'h2000 + 32'($urandom_range(0, 255));
      else             o.a = MMIO_ADDR + 32'h4;
      o.d = $urandom;
      ops.push_back(o);
    end
    for (int k = 0; k <= ops.size(); k++) begin
      if (k < ops.size()) begin
        drive(ops[k]);
        model(ops[k], mv, mf, md);
        xv.push_back(mv); xf.push_back(mf); xd.push_back(md); xm.push_back(mmio_ref);
      end else begin
        drive(mk(0, 0, 0, 3'd0, 32'd0, 32'd0));
      end
      @(posedge clk);
      #1;
      if (k >= 1) begin
        total++;
        if (load_valid_wb !== xv[k-1]) begin
          bad++; $display("FAIL random op%0d load_valid got %b want %b", k-1, load_valid_wb, xv[k-1]);
        end
        total++;
        if (fault_wb !== xf[k-1]) begin
          bad++; $display("FAIL random op%0d fault got %b want %b", k-1, fault_wb, xf[k-1]);
        end
        total++;
        if (load_data_wb !== xd[k-1]) begin
          bad++; $display("FAIL random op%0d load_data got %h want %h", k-1, load_data_wb, xd[k-1]);
        end
        total++;
        if (mmio_out !== xm[k-1]) begin
          bad++; $display("FAIL random op%0d mmio_out got %h want %h", k-1, mmio_out, xm[k-1]);
        end
        $display("random op%0d v=%b ld=%b st=%b f3=%0d a=%h data=%h fault=%b",
                 k-1, ops[k-1].v, ops[k-1].ld, ops[k-1].st, ops[k-1].f3, ops[k-1].a,
                 load_data_wb, fault_wb);
      end
    end
  endtask

  // Store whose X cycle coincides with reset must not reach memory.
  task automatic test_reset_mid();
    drive(mk(1, 0, 1, 3'd2, 32'h20, 32'h1111_1111));
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 3'd0, 32'd0, 32'd0));
    repeat (3) @(posedge clk);
    #1;
    drive(mk(1, 0, 1, 3'd2, 32'h20, 32'h0000_1234));
    @(posedge clk); #1;
    rst = 1'b1;
    drive(mk(0, 0, 0, 3'd0, 32'd0, 32'd0));
    @(posedge clk); #1;
    total++;
    if (load_valid_wb !== 1'b0 || fault_wb !== 2'b00 || load_data_wb !== 32'd0) begin
      bad++; $display("FAIL reset_mid outputs got valid=%b fault=%b data=%h want 0/00/00000000",
                      load_valid_wb, fault_wb, load_data_wb);
    end
    total++;
    if (mmio_out !== 32'd0) begin
      bad++; $display("FAIL reset_mid mmio_out got %h want 00000000", mmio_out);
    end
    rst = 1'b0;
    mmio_ref = 32'd0;
    drive(mk(1, 1, 0, 3'd2, 32'h20, 32'd0));
    @(posedge clk); #1;
    drive(mk(0, 0, 0, 3'd0, 32'd0, 32'd0));
    @(posedge clk); #1;
    total++;
    if (load_valid_wb !== 1'b1 || fault_wb !== 2'b00) begin
      bad++; $display("FAIL reset_mid reload status got valid=%b fault=%b want 1/00",
                      load_valid_wb, fault_wb);
    end
    total++;
    if (load_data_wb !== 32'h1111_1111) begin
      bad++; $display("FAIL reset_mid reload data got %h want 11111111", load_data_wb);
    end
    $display("reset_mid: reload a=00000020 data=%h mmio=%h", load_data_wb, mmio_out);
  endtask

  initial begin
    rst = 1'b1;
    drive(mk(0, 0, 0, 3'd0, 32'd0, 32'd0));
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access path for the core's MEMPREP and MEMEX stages, fed directly by the EX-MEMPREP pipeline register. It decodes and aligns each load/store, drives a byte-enabled synchronous data TCM plus one memory-mapped output register, and presents aligned, extended load data in the WB stage. The WB stage consumes this data through the rd-data mux and the forwarding path. The block never stalls; it accepts one operation per cycle.

## Interface
- DTCM_ADDR_W, 12: byte-address width of data TCM (4 KiB, word-organised, 2^(DTCM_ADDR_W-2) words)
- MMIO_BASE, 32'h8000_0000: word address of the memory-mapped output register
- clk  in  1  core clock; single clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  MEMPREP slot holds a valid instruction (~invalid_MEMPREP)
- mem_load  in  1  instruction is a load
- mem_store  in  1  instruction is a store
- mem_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective byte address (alu_result_MEMPREP)
- store_data  in  32  rs2 value, unaligned (low bits significant)
- load_data_wb  out  32  extended load result, valid in WB stage
- load_valid_wb  out  1  WB slot holds a completed valid load
- fault_wb  out  2  00 none, 01 misaligned, 10 access fault, 11 illegal op
- mmio_out  out  32  memory-mapped output register contents

## Operation
- Stage P (MEMPREP, comb): decode into region (DTCM if addr[31:DTCM_ADDR_W]==0; MMIO if addr[31:2]==MMIO_BASE[31:2]; else none), byte enables, store data shifted to lane addr[1:0], fault cause.
- Byte enables: B/BU 4'b0001<<addr[1:0]; H/HU 4'b0011<<addr[1:0]; W 4'b1111.
- Fault priority: illegal (mem_load&mem_store, or funct3 in {011,110,111} with either set) > misaligned (H/HU with addr[0]=1, W with addr[1:0]!=0) > access fault (region none). Faulting ops perform no write; loads return 0.
- Ops with in_valid=0 or neither load nor store: no access, no fault, load_valid_wb=0.
- P->X register: valid, load, store, region, word index, byte enables, aligned data, addr[1:0], funct3, fault.
- Stage X (MEMEX): DTCM write with per-byte enables when valid&store&fault==0&region==DTCM&~rst; MMIO write likewise into mmio_out, honouring byte enables. Read data captured on the same edge: DTCM read (read-first) or mmio_out old value.
- X->W register: valid&load, addr[1:0], funct3, fault, region.
- Stage W (comb): select lane by addr[1:0]; B/H sign-extend bit 7/15; BU/HU zero-extend; W pass-through. load_data_wb=0 unless valid load without fault.

## Timing
- Op presented in cycle N (P); DTCM/MMIO write at end of N+1; load_data_wb, load_valid_wb, fault_wb valid throughout N+2 (aligned with core's WB stage); mmio_out reflects a store from cycle N+2.
- Back-to-back store(N) then load same address (N+1): load returns new data (write at end of N+1, read at end of N+2).
- Store then load in consecutive cycles to different byte lanes of one word: unwritten lanes retain old contents.
- Reset: all stage valid bits cleared; load_data_wb=0, load_valid_wb=0, fault_wb=0, mmio_out=0 the cycle after rst sampled high. DTCM contents not reset.
- Reset mid-operation: a store in stage X while rst=1 is suppressed (no DTCM/MMIO write); in-flight ops are discarded.
- No back-pressure; in_valid may be high every cycle.

## Test plan
- SW addr 0x10 data 0xDEADBEEF at N, LW 0x10 at N+1 -> load_data_wb=0xDEADBEEF in N+3, fault 00.
- After above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x55 then LW 0x10 -> 0xDEAD55EF (other lanes preserved).
- SH 0x11 and LW 0x12 -> fault 01, no write (LW 0x10 still 0xDEAD55EF), load_data_wb=0; LW 0x2000 -> fault 10; funct3 011 -> fault 11.
- SW 0x8000_0000 data 0x0000000A -> mmio_out=0xA from cycle N+2; LW 0x8000_0000 -> 0xA; SB 0x8000_0001 data 0xFF -> mmio_out=0x0000FF0A.
- SW 0x20 data 0x1234 with rst asserted during its X cycle -> LW 0x20 after reset returns pre-reset contents; all outputs 0 after reset.
